sync_fifo_flex: RTL and testbench
=================================

# sync_fifo_flex

Parametrised synchronous FIFO, the next generation of the team's UART byte buffer. It adds a selectable first-word-fall-through (FWFT) read mode, exact same-cycle status flags, a fill level output, programmable almost-full/almost-empty thresholds, sticky overflow/underflow error flags and a synchronous flush. It sits between the UART RX/TX datapaths and the case-conversion logic, replacing the fixed 16×8 buffer.

## Interface
- WIDTH, 8: data width in bits, ≥1.
- DEPTH, 16: number of entries, power of two, ≥2.
- FWFT, 0: read mode. 0 = standard (registered read), 1 = first-word-fall-through.
- AF_THRESH, DEPTH-2: almost_full asserts when level ≥ AF_THRESH.
- AE_THRESH, 2: almost_empty asserts when level ≤ AE_THRESH.
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous clear of contents and error flags.
- wr_en  in  1  write request.
- din  in  WIDTH  write data.
- rd_en  in  1  read (pop) request.
- dout  out  WIDTH  read data.
- dout_valid  out  1  standard mode: 1-cycle pulse marking a new dout. FWFT mode: equals !empty.
- full  out  1  level == DEPTH.
- empty  out  1  level == 0.
- almost_full  out  1  level ≥ AF_THRESH.
- almost_empty  out  1  level ≤ AE_THRESH.
- level  out  $clog2(DEPTH)+1  number of stored words, 0..DEPTH.
- overflow  out  1  sticky: a write was dropped.
- underflow  out  1  sticky: a read was rejected.

## Operation
- Reset values: dout 0, dout_valid 0, level 0, full 0, empty 1, almost_full 0, almost_empty 1, overflow 0, underflow 0. Pointers are 0.
- Pointers are $clog2(DEPTH) bits wide and wrap naturally from DEPTH-1 to 0.
- Write is accepted when wr_en && (!full || rd_accept). Otherwise, when wr_en is high and the write is not accepted, overflow is set.
- Read is accepted (rd_accept) when rd_en && !empty. When rd_en is high and empty is 1, underflow is set. The read is rejected even if a write occurs in the same cycle; there is no bypass.
- level update: +1 for write only, −1 for read only, unchanged when both or neither are accepted.
- Flags are decoded from the registered level and reflect the current contents. There is no extra cycle of lag.
- Standard mode: on an accepted read, dout is loaded with mem[rd_ptr] and dout_valid pulses high for one cycle. Otherwise dout holds its value and dout_valid is 0.
- FWFT mode:
  - dout = mem[rd_ptr] whenever !empty.
  - rd_en acknowledges and pops the current head.
  - dout is 0 when empty.
- flush has priority over wr_en/rd_en in the same cycle.
  - Clears pointers, level, overflow and underflow, and sets dout_valid to 0.
  - dout holds in standard mode.
- Asserting rst_n low mid-operation immediately forces all outputs to their reset values. Memory contents are don't-care.

## Timing
- Write to empty FIFO at edge N: empty falls and level = 1 after edge N. In FWFT mode, dout shows the word in the same cycle.
- Standard read: rd_en sampled at edge N, dout/dout_valid valid after edge N (1-cycle latency).
- FWFT read: head data is available combinationally. A pop at edge N presents the next word after edge N.
- full asserts after the edge of the DEPTH-th accepted write. On a full FIFO, a simultaneous read and write keeps full = 1.
- overflow and underflow set after the edge of the offending request and hold until flush or reset.

## Structure
- Shared package fifo_pkg: FWFT mode constants (FIFO_STD=0, FIFO_FWFT=1) and the level-width rule ($clog2(DEPTH)+1) as a function.
- One sub-module, fifo_mem: a WIDTH×DEPTH register array with one synchronous write port and one asynchronous read port. It is not reset.
- Pointer, level, flag and output logic live in sync_fifo_flex.

## Test plan
- DEPTH=4, FWFT=0:
  - Write 0x41,0x42,0x43,0x44, then one more write of 0x45 → level=4, full=1, almost_full=1, overflow=1.
  - Four reads → dout 0x41..0x44, one dout_valid pulse each, empty=1 at the end.
- DEPTH=4, FWFT=1: write 0x61 to an empty FIFO → after that edge, empty=0 and dout=0x61. Pop → empty=1.
- Full FIFO with wr_en=1 and rd_en=1 in the same cycle, din=0x5A → level stays 4, oldest word is output, 0x5A is read fourth afterwards, overflow stays 0.
- Empty FIFO with rd_en=1 and wr_en=1, din=0x30 → read rejected, underflow=1, level=1, next read returns 0x30.
- Level 3 with flush=1 and wr_en=1 → level=0, empty=1, overflow=0, underflow=0, write ignored.
- Assert rst_n low mid-burst at level 2 → outputs take their reset values immediately. After release, a write of 0x7E followed by a read returns 0x7E.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared FIFO definitions: read-mode selectors and the level-width rule.
package fifo_pkg;

  localparam int unsigned FIFO_STD  = 0;
  localparam int unsigned FIFO_FWFT = 1;

  // The level counter must represent 0..DEPTH inclusive, hence one extra bit.
  function automatic int unsigned level_width(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/fifo_mem.sv
// WIDTH x DEPTH register array: one synchronous write port, one asynchronous read port.
// Contents are intentionally not reset.
module fifo_mem #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             wr_en_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic [AW-1:0]    raddr_i,
  output logic [WIDTH-1:0] rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/sync_fifo_flex.sv
// Synchronous FIFO with standard or first-word-fall-through read, exact status flags,
// fill level, almost thresholds, sticky overflow/underflow and synchronous flush.
module sync_fifo_flex
  import fifo_pkg::*;
#(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned DEPTH     = 16,
  parameter int unsigned FWFT      = FIFO_STD,
  parameter int unsigned AF_THRESH = DEPTH - 2,
  parameter int unsigned AE_THRESH = 2
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 flush,
  input  logic                                 wr_en,
  input  logic [WIDTH-1:0]                     din,
  input  logic                                 rd_en,
  output logic [WIDTH-1:0]                     dout,
  output logic                                 dout_valid,
  output logic                                 full,
  output logic                                 empty,
  output logic                                 almost_full,
  output logic                                 almost_empty,
  output logic [level_width(DEPTH)-1:0]        level,
  output logic                                 overflow,
  output logic                                 underflow
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = level_width(DEPTH);

  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]    level_q, level_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;
  logic             rd_accept, wr_accept;
  logic [WIDTH-1:0] rdata;

  // Flags decode straight from the registered level so they track contents with no lag.
  assign full         = (level_q == LW'(DEPTH));
  assign empty        = (level_q == '0);
  assign almost_full  = (level_q >= LW'(AF_THRESH));
  assign almost_empty = (level_q <= LW'(AE_THRESH));
  assign level        = level_q;
  assign overflow     = ovf_q;
  assign underflow    = unf_q;

  // A read on an empty FIFO is rejected even if a write lands in the same cycle.
  assign rd_accept = rd_en && !empty;
  assign wr_accept = wr_en && (!full || rd_accept);

  fifo_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk     (clk),
    .wr_en_i (wr_accept && !flush),
    .waddr_i (wr_ptr_q),
    .wdata_i (din),
    .raddr_i (rd_ptr_q),
    .rdata_o (rdata)
  );

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    ovf_d    = ovf_q;
    unf_d    = unf_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
      ovf_d    = 1'b0;
      unf_d    = 1'b0;
    end else begin
      if (wr_accept) wr_ptr_d = wr_ptr_q + AW'(1);
      if (rd_accept) rd_ptr_d = rd_ptr_q + AW'(1);
      if (wr_accept && !rd_accept)      level_d = level_q + LW'(1);
      else if (rd_accept && !wr_accept) level_d = level_q - LW'(1);
      if (wr_en && !wr_accept) ovf_d = 1'b1;
      if (rd_en && empty)      unf_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
    end
  end

  generate
    if (FWFT == FIFO_FWFT) begin : g_fwft
      assign dout       = empty ? '0 : rdata;
      assign dout_valid = !empty;
    end else begin : g_std
      logic [WIDTH-1:0] dout_q, dout_d;
      logic             dv_q, dv_d;

      // Flush drops the valid pulse but leaves the last presented word on dout.
      always_comb begin
        dout_d = dout_q;
        dv_d   = 1'b0;
        if (!flush && rd_accept) begin
          dout_d = rdata;
          dv_d   = 1'b1;
        end
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          dout_q <= '0;
          dv_q   <= 1'b0;
        end else begin
          dout_q <= dout_d;
          dv_q   <= dv_d;
        end
      end

      assign dout       = dout_q;
      assign dout_valid = dv_q;
    end
  endgenerate

endmodule

// File: tb/tb_sync_fifo_flex.sv
// Self-checking bench: a standard-mode and an FWFT-mode DEPTH=4 FIFO against a queue scoreboard.
module tb_sync_fifo_flex;

  localparam int unsigned W  = 8;
  localparam int unsigned D  = 4;
  localparam int unsigned LW = 3;

  logic clk = 1'b0;
  logic rst_n;

  logic          s_flush, s_wr, s_rd;
  logic [W-1:0]  s_din, s_dout;
  logic          s_dv, s_full, s_empty, s_af, s_ae, s_ovf, s_unf;
  logic [LW-1:0] s_level;

  logic          f_flush, f_wr, f_rd;
  logic [W-1:0]  f_din, f_dout;
  logic          f_dv, f_full, f_empty, f_af, f_ae, f_ovf, f_unf;
  logic [LW-1:0] f_level;

  int checks = 0;
  int errors = 0;
  logic [W-1:0] sb_q[$];
  logic [W-1:0] exp_w;

  always #5 clk = ~clk;

  sync_fifo_flex #(.WIDTH(W), .DEPTH(D), .FWFT(0)) u_std (
    .clk(clk), .rst_n(rst_n), .flush(s_flush), .wr_en(s_wr), .din(s_din), .rd_en(s_rd),
    .dout(s_dout), .dout_valid(s_dv), .full(s_full), .empty(s_empty),
    .almost_full(s_af), .almost_empty(s_ae), .level(s_level),
    .overflow(s_ovf), .underflow(s_unf)
  );

  sync_fifo_flex #(.WIDTH(W), .DEPTH(D), .FWFT(1)) u_fwft (
    .clk(clk), .rst_n(rst_n), .flush(f_flush), .wr_en(f_wr), .din(f_din), .rd_en(f_rd),
    .dout(f_dout), .dout_valid(f_dv), .full(f_full), .empty(f_empty),
    .almost_full(f_af), .almost_empty(f_ae), .level(f_level),
    .overflow(f_ovf), .underflow(f_unf)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp_v);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic s_write(input logic [W-1:0] d);
    s_wr = 1'b1; s_din = d; sb_q.push_back(d);
    step();
    s_wr = 1'b0;
  endtask

  task automatic s_read_check(input string tag);
    s_rd = 1'b1;
    exp_w = sb_q.pop_front();
    step();
    s_rd = 1'b0;
    chk({tag, "_dout"}, 32'(s_dout), 32'(exp_w));
    chk({tag, "_dv"}, 32'(s_dv), 32'd1);
  endtask

  initial begin
    rst_n = 1'b0;
    s_flush = 0; s_wr = 0; s_rd = 0; s_din = '0;
    f_flush = 0; f_wr = 0; f_rd = 0; f_din = '0;
    #12;
    chk("rst_dout", 32'(s_dout), 32'h0);
    chk("rst_dv", 32'(s_dv), 32'd0);
    chk("rst_level", 32'(s_level), 32'd0);
    chk("rst_full", 32'(s_full), 32'd0);
    chk("rst_empty", 32'(s_empty), 32'd1);
    chk("rst_af", 32'(s_af), 32'd0);
    chk("rst_ae", 32'(s_ae), 32'd1);
    chk("rst_ovf_unf", 32'({s_ovf, s_unf}), 32'd0);
    chk("rst_f_dout", 32'(f_dout), 32'h0);
    rst_n = 1'b1;
    step();

    // Fill to full, then one dropped write.
    for (int i = 0; i < 4; i++) s_write(W'(8'h41 + i));
    chk("fill_ae_l4", 32'(s_ae), 32'd0);
    s_wr = 1'b1; s_din = 8'h45;
    step();
    s_wr = 1'b0;
    chk("ovf_level", 32'(s_level), 32'd4);
    chk("ovf_full", 32'(s_full), 32'd1);
    chk("ovf_af", 32'(s_af), 32'd1);
    chk("ovf_flag", 32'(s_ovf), 32'd1);

    // Drain with a gap cycle after each read to see the single-cycle valid pulse.
    for (int i = 0; i < 4; i++) begin
      s_read_check("drain");
      step();
      chk("drain_pulse", 32'(s_dv), 32'd0);
    end
    chk("drain_empty", 32'(s_empty), 32'd1);
    chk("drain_ovf_sticky", 32'(s_ovf), 32'd1);
    s_flush = 1'b1; step(); s_flush = 1'b0;
    chk("flush_ovf", 32'(s_ovf), 32'd0);

    // Simultaneous read and write on a full FIFO.
    for (int i = 1; i <= 4; i++) s_write(W'(i));
    s_wr = 1'b1; s_rd = 1'b1; s_din = 8'h5A;
    exp_w = sb_q.pop_front();
    sb_q.push_back(8'h5A);
    step();
    s_wr = 1'b0; s_rd = 1'b0;
    chk("rw_full_level", 32'(s_level), 32'd4);
    chk("rw_full_full", 32'(s_full), 32'd1);
    chk("rw_full_dout", 32'(s_dout), 32'(exp_w));
    chk("rw_full_ovf", 32'(s_ovf), 32'd0);
    for (int i = 0; i < 4; i++) s_read_check("rw_drain");

    // Read on empty with a concurrent write: read rejected, write kept.
    s_wr = 1'b1; s_rd = 1'b1; s_din = 8'h30; sb_q.push_back(8'h30);
    step();
    s_wr = 1'b0; s_rd = 1'b0;
    chk("unf_flag", 32'(s_unf), 32'd1);
    chk("unf_level", 32'(s_level), 32'd1);
    chk("unf_dv", 32'(s_dv), 32'd0);
    s_read_check("unf_next");

    // Flush beats a concurrent write.
    for (int i = 0; i < 3; i++) s_write(W'(8'h10 + i));
    chk("l3_level", 32'(s_level), 32'd3);
    chk("l3_ae", 32'(s_ae), 32'd0);
    s_flush = 1'b1; s_wr = 1'b1; s_din = 8'hEE;
    step();
    s_flush = 1'b0; s_wr = 1'b0;
    sb_q.delete();
    chk("flush_level", 32'(s_level), 32'd0);
    chk("flush_empty", 32'(s_empty), 32'd1);
    chk("flush_flags", 32'({s_ovf, s_unf}), 32'd0);

    // Asynchronous reset mid-burst.
    s_write(8'h21);
    s_write(8'h22);
    chk("prerst_level", 32'(s_level), 32'd2);
    s_rd = 1'b1; step();
    s_wr = 1'b1; s_rd = 1'b0; s_din = 8'h23;
    #3 rst_n = 1'b0;
    #1;
    chk("arst_level", 32'(s_level), 32'd0);
    chk("arst_empty", 32'(s_empty), 32'd1);
    chk("arst_dout", 32'(s_dout), 32'h0);
    chk("arst_ae_af", 32'({s_ae, s_af}), 32'b10);
    s_wr = 1'b0;
    sb_q.delete();
    #2 rst_n = 1'b1;
    step();
    s_write(8'h7E);
    s_read_check("post_rst");

    // FWFT: head visible right after the write edge.
    f_wr = 1'b1; f_din = 8'h61;
    step();
    f_wr = 1'b0;
    chk("fwft_empty", 32'(f_empty), 32'd0);
    chk("fwft_dout", 32'(f_dout), 32'h61);
    chk("fwft_dv", 32'(f_dv), 32'd1);
    f_rd = 1'b1;
    step();
    f_rd = 1'b0;
    chk("fwft_pop_empty", 32'(f_empty), 32'd1);
    chk("fwft_pop_dout", 32'(f_dout), 32'h0);
    chk("fwft_pop_dv", 32'(f_dv), 32'd0);
    f_wr = 1'b1; f_din = 8'h62; step();
    f_din = 8'h63; step();
    f_wr = 1'b0;
    f_rd = 1'b1; step(); f_rd = 1'b0;
    chk("fwft_next", 32'(f_dout), 32'h63);
    chk("fwft_next_level", 32'(f_level), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
